// File: rtl/ls_preload_loader.sv
// LocalStore preload loader: packs SRC_W-bit source beats big-endian into
// 128-bit quadwords and writes them to consecutive quadword addresses.
module ls_preload_loader #(
    parameter int SRC_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [14:0]       base_addr,
    input  logic [11:0]       qw_count,
    input  logic              src_valid,
    input  logic [SRC_W-1:0]  src_data,
    output logic              src_ready,
    output logic              preload_LS_en,
    output logic [14:0]       preload_LS_addr,
    output logic [127:0]      preload_LS_data,
    output logic              busy,
    output logic              done,
    output logic              err_wrap
);

    // state | meaning
    // IDLE  | waiting for start
    // FILL  | accepting source beats into the quadword buffer
    // WRITE | one-cycle LocalStore write strobe
    // DONE  | one-cycle done pulse, then IDLE
    localparam int BEATS = 128 / SRC_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [BW-1:0]  beat;
    logic [BW-1:0]  beat_nxt;
    logic [127:0]   buffer;
    logic [127:0]   buffer_nxt;
    logic [14:0]    addr;
    logic [11:0]    rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        beat_nxt   = beat;
        buffer_nxt = buffer;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (qw_count == 12'd0) ? DONE : FILL;
                    beat_nxt  = '0;
                end
            end
            FILL: begin
                if (abort) begin
                    state_nxt = DONE;
                    beat_nxt  = '0;
                end else if (src_valid) begin
                    // Beat 0 occupies the most significant slice (big-endian bit 0).
                    buffer_nxt[127 - int'(beat) * SRC_W -: SRC_W] = src_data;
                    if (beat == LAST_BEAT) begin
                        state_nxt = WRITE;
                        beat_nxt  = '0;
                    end else begin
                        beat_nxt = beat + BW'(1);
                    end
                end
            end
            WRITE: begin
                state_nxt = (abort || rem == 12'd1) ? DONE : FILL;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat            <= '0;
            buffer          <= '0;
            addr            <= '0;
            rem             <= '0;
            err_wrap        <= 1'b0;
            src_ready       <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            preload_LS_en   <= 1'b0;
            preload_LS_addr <= '0;
            preload_LS_data <= '0;
        end else begin
            beat          <= beat_nxt;
            buffer        <= buffer_nxt;
            src_ready     <= (state_nxt == FILL);
            busy          <= (state_nxt != IDLE);
            done          <= (state_nxt == DONE);
            preload_LS_en <= (state_nxt == WRITE);
            // Write port registers only change on entry to WRITE, so they hold otherwise.
            if (state_nxt == WRITE) begin
                preload_LS_addr <= addr;
                preload_LS_data <= buffer_nxt;
            end
            if (state == IDLE && start) begin
                addr     <= {base_addr[14:4], 4'b0000};
                rem      <= qw_count;
                err_wrap <= 1'b0;
            end
            if (state == WRITE) begin
                addr <= addr + 15'd16;
                rem  <= rem - 12'd1;
                if (addr == 15'h7FF0) err_wrap <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ls_preload_loader.sv
// Directed self-checking bench for ls_preload_loader with a 32-bit source.
module tb_ls_preload_loader;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [14:0]   base_addr;
    logic [11:0]   qw_count;
    logic          src_valid;
    logic [31:0]   src_data;
    logic          src_ready;
    logic          preload_LS_en;
    logic [14:0]   preload_LS_addr;
    logic [127:0]  preload_LS_data;
    logic          busy;
    logic          done;
    logic          err_wrap;

    int n_chk  = 0;
    int n_fail = 0;
    int en_cnt = 0;
    int done_cnt = 0;
    int en_base;
    int done_base;

    ls_preload_loader #(.SRC_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .base_addr       (base_addr),
        .qw_count        (qw_count),
        .src_valid       (src_valid),
        .src_data        (src_data),
        .src_ready       (src_ready),
        .preload_LS_en   (preload_LS_en),
        .preload_LS_addr (preload_LS_addr),
        .preload_LS_data (preload_LS_data),
        .busy            (busy),
        .done            (done),
        .err_wrap        (err_wrap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (preload_LS_en) en_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic kick(input logic [14:0] base, input logic [11:0] cnt);
        start     = 1'b1;
        base_addr = base;
        qw_count  = cnt;
        step();
        start = 1'b0;
    endtask

    // Sends one quadword, checks the write strobe cycle, then leaves WRITE.
    task automatic send_qw(input logic [127:0] qw, input bit throttle,
                           input logic [14:0] exp_addr, input string tag);
        for (int i = 0; i < 4; i++) begin
            src_valid = 1'b1;
            src_data  = qw[127 - 32*i -: 32];
            step();
            if (throttle && i < 3) begin
                src_valid = 1'b0;
                src_data  = 32'hBAD0_0000 | 32'(i);
                step();
            end
        end
        src_valid = throttle;
        src_data  = 32'hDEAD_BEEF;
        chk({tag, "_en"},    128'(preload_LS_en), 128'd1);
        chk({tag, "_addr"},  128'(preload_LS_addr), 128'(exp_addr));
        chk({tag, "_data"},  preload_LS_data, qw);
        chk({tag, "_ready"}, 128'(src_ready), 128'd0);
        step();
        src_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; base_addr = '0; qw_count = '0;
        src_valid = 1'b0; src_data = '0;
        step(); step();
        chk("rst_busy",  128'(busy), 128'd0);
        chk("rst_done",  128'(done), 128'd0);
        chk("rst_en",    128'(preload_LS_en), 128'd0);
        chk("rst_ready", 128'(src_ready), 128'd0);
        chk("rst_addr",  128'(preload_LS_addr), 128'd0);
        chk("rst_data",  preload_LS_data, 128'd0);
        chk("rst_wrap",  128'(err_wrap), 128'd0);
        rst = 1'b0;
        step();

        // single quadword, back-to-back beats
        en_base = en_cnt;
        kick(15'h0100, 12'd1);
        chk("t1_ready", 128'(src_ready), 128'd1);
        chk("t1_busy",  128'(busy), 128'd1);
        send_qw(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0, 15'h0100, "t1");
        chk("t1_done",   128'(done), 128'd1);
        chk("t1_en_off", 128'(preload_LS_en), 128'd0);
        step();
        chk("t1_idle",  128'(busy), 128'd0);
        chk("t1_done0", 128'(done), 128'd0);
        chk("t1_hold",  128'(preload_LS_addr), 128'h0100);
        chk("t1_encnt", 128'(en_cnt - en_base), 128'd1);

        // throttled source, three quadwords
        en_base = en_cnt;
        kick(15'h0200, 12'd3);
        send_qw(128'h01020304_05060708_090A0B0C_0D0E0F10, 1'b1, 15'h0200, "t2a");
        send_qw(128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3, 1'b1, 15'h0210, "t2b");
        send_qw(128'hFFFFFFFF_00000000_12345678_9ABCDEF0, 1'b1, 15'h0220, "t2c");
        chk("t2_done", 128'(done), 128'd1);
        step();
        chk("t2_idle",  128'(busy), 128'd0);
        chk("t2_encnt", 128'(en_cnt - en_base), 128'd3);

        // zero-length
        en_base = en_cnt;
        kick(15'h0300, 12'd0);
        chk("t3_busy",  128'(busy), 128'd1);
        chk("t3_done",  128'(done), 128'd1);
        chk("t3_ready", 128'(src_ready), 128'd0);
        step();
        chk("t3_idle",  128'(busy), 128'd0);
        chk("t3_encnt", 128'(en_cnt - en_base), 128'd0);

        // address wrap with sticky err_wrap
        kick(15'h7FF5, 12'd2);
        chk("t4_wrap0", 128'(err_wrap), 128'd0);
        send_qw(128'h11111111_22222222_33333333_44444444, 1'b0, 15'h7FF0, "t4a");
        chk("t4_wrap1", 128'(err_wrap), 128'd1);
        send_qw(128'h55555555_66666666_77777777_88888888, 1'b0, 15'h0000, "t4b");
        chk("t4_done", 128'(done), 128'd1);
        step(); step();
        chk("t4_sticky", 128'(err_wrap), 128'd1);

        // abort after two beats of the second quadword
        en_base = en_cnt;
        done_base = done_cnt;
        kick(15'h0300, 12'd4);
        chk("t5_wrapclr", 128'(err_wrap), 128'd0);
        send_qw(128'hCAFE0001_CAFE0002_CAFE0003_CAFE0004, 1'b0, 15'h0300, "t5a");
        src_valid = 1'b1; src_data = 32'h99990001; step();
        src_valid = 1'b1; src_data = 32'h99990002; step();
        src_valid = 1'b0; abort = 1'b1; step();
        abort = 1'b0;
        chk("t5_done", 128'(done), 128'd1);
        chk("t5_en",   128'(preload_LS_en), 128'd0);
        step();
        chk("t5_idle",   128'(busy), 128'd0);
        chk("t5_encnt",  128'(en_cnt - en_base), 128'd1);
        chk("t5_dncnt",  128'(done_cnt - done_base), 128'd1);
        kick(15'h0400, 12'd1);
        send_qw(128'h0BADF00D_12121212_34343434_56565656, 1'b0, 15'h0400, "t5r");
        chk("t5r_done", 128'(done), 128'd1);
        step();

        // reset mid-FILL
        done_base = done_cnt;
        kick(15'h0500, 12'd2);
        src_valid = 1'b1; src_data = 32'h1; step();
        src_valid = 1'b1; src_data = 32'h2; step();
        src_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t6_busy",  128'(busy), 128'd0);
        chk("t6_ready", 128'(src_ready), 128'd0);
        chk("t6_addr",  128'(preload_LS_addr), 128'd0);
        chk("t6_data",  preload_LS_data, 128'd0);
        step(); step();
        rst = 1'b0;
        step();
        chk("t6_nodone", 128'(done_cnt - done_base), 128'd0);

        // start+abort in IDLE: start wins; later start while busy is ignored
        en_base = en_cnt;
        start = 1'b1; abort = 1'b1; base_addr = 15'h0600; qw_count = 12'd2;
        step();
        start = 1'b0; abort = 1'b0;
        chk("t7_ready", 128'(src_ready), 128'd1);
        start = 1'b1; base_addr = 15'h7000; qw_count = 12'd1;
        step();
        start = 1'b0;
        send_qw(128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333, 1'b0, 15'h0600, "t7a");
        chk("t7_nodone", 128'(done), 128'd0);
        send_qw(128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0, 1'b0, 15'h0610, "t7b");
        chk("t7_done", 128'(done), 128'd1);
        step();
        chk("t7_encnt", 128'(en_cnt - en_base), 128'd2);
        chk("t7_idle",  128'(busy), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
